// File: rtl/gray_pkg.sv
// gray_pkg: Gray/binary conversion helpers shared by the Gray counter and
// async-FIFO pointer logic. Both functions work on a MAX_W-bit word; callers
// zero-extend narrower values in and truncate the result back to their own
// width. Zero upper bits give the same low-order result as a native-width
// conversion, so one function pair serves every width up to MAX_W.
package gray_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: b[i] = g[MAX_W-1] ^ ... ^ g[i]
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_updown_counter_if.sv
// gray_updown_counter_if: control and count bus of the Gray up/down counter.
//   en, up, load, load_gray : control, driven by the master
//   gray, bin, wrap         : registered count outputs, driven by the counter
interface gray_updown_counter_if #(
  parameter int N = 4
);

  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] load_gray;
  logic [N-1:0] gray;
  logic [N-1:0] bin;
  logic         wrap;

  modport master (
    output en, up, load, load_gray,
    input  gray, bin, wrap
  );

  modport slave (
    input  en, up, load, load_gray,
    output gray, bin, wrap
  );

endinterface

// File: rtl/gray2bin_conv.sv
// gray2bin_conv: combinational W-bit Gray-to-binary converter.
//   g : Gray-coded input
//   b : binary equivalent
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  assign b = W'(gray2bin(word_t'(g)));

endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: N-bit up/down Gray counter with synchronous load and
// a registered binary shadow. All outputs come straight from flops, so gray
// may be synchronised into another clock domain.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : slave side of gray_updown_counter_if (en, up, load, load_gray in;
//          gray, bin, wrap out)
// Priority at each edge: reset, load, count, hold.
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  gray_updown_counter_if.slave        bus
);

  localparam logic [N-1:0] GRAY_RST = N'(bin2gray(word_t'(RST_VAL)));

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         wrap_q;
  logic [N-1:0] load_bin;
  logic [N-1:0] bin_nxt;
  logic         wrap_nxt;

  gray2bin_conv #(.W(N)) u_load_conv (
    .g (bus.load_gray),
    .b (load_bin)
  );

  // Step value and boundary detection; only used when en is honoured.
  always_comb begin
    bin_nxt  = bin_q;
    wrap_nxt = 1'b0;
    if (bus.up) begin
      bin_nxt  = bin_q + N'(1);
      wrap_nxt = (bin_q == '1);
    end else begin
      bin_nxt  = bin_q - N'(1);
      wrap_nxt = (bin_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bin_q  <= RST_VAL;
      gray_q <= GRAY_RST;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      bin_q  <= load_bin;
      gray_q <= bus.load_gray;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      bin_q  <= bin_nxt;
      gray_q <= N'(bin2gray(word_t'(bin_nxt)));
      wrap_q <= wrap_nxt;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.gray = gray_q;
  assign bus.bin  = bin_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

  typedef struct packed {
    logic [5:0] gray;
    logic [5:0] bin;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  gray_updown_counter_if #(.N(4)) if_a ();
  gray_updown_counter_if #(.N(4)) if_b ();
  gray_updown_counter_if #(.N(6)) if_c ();

  gray_updown_counter #(.N(4), .RST_VAL(4'h0)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  gray_updown_counter #(.N(4), .RST_VAL(4'h5)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
  gray_updown_counter #(.N(6), .RST_VAL(6'h0)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c));

  int n_cmp = 0;
  int n_err = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int unsigned ma = 0;
  int unsigned mb = 0;
  int unsigned mc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Gray to binary as XOR of all right shifts of g
  function automatic int unsigned mdl_g2b(input int w, input int unsigned g);
    int unsigned b;
    b = g;
    for (int s = 1; s < w; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int unsigned mdl_next(input int w, input int unsigned cur,
                                           input int unsigned rv, input int unsigned lg,
                                           input bit r, input bit ld, input bit e, input bit u,
                                           output bit wr);
    int unsigned mask;
    mask = (32'd1 << w) - 32'd1;
    wr = 1'b0;
    if (!r) return rv;
    if (ld) return mdl_g2b(w, lg & mask);
    if (e) begin
      if (u) begin
        wr = (cur == mask);
        return (cur + 32'd1) & mask;
      end else begin
        wr = (cur == 32'd0);
        return (cur - 32'd1) & mask;
      end
    end
    return cur;
  endfunction

  function automatic exp_t mk(input int unsigned b, input bit w);
    exp_t x;
    x.gray = 6'(b ^ (b >> 1));
    x.bin  = 6'(b);
    x.wrap = w;
    return x;
  endfunction

  task automatic step(input int r, input int ld, input int lg, input int e, input int u);
    bit wa, wb, wc;
    bit rb, lb, eb, ub;
    exp_t ea, eb_, ec;
    logic [5:0] pg;
    rb = (r != 0); lb = (ld != 0); eb = (e != 0); ub = (u != 0);
    rstn = rb;
    if_a.load = lb; if_a.en = eb; if_a.up = ub; if_a.load_gray = 4'(lg);
    if_b.load = lb; if_b.en = eb; if_b.up = ub; if_b.load_gray = 4'(lg);
    if_c.load = lb; if_c.en = eb; if_c.up = ub; if_c.load_gray = 6'(lg);
    ma = mdl_next(4, ma, 32'd0, 32'(lg), rb, lb, eb, ub, wa);
    qa.push_back(mk(ma, wa));
    mb = mdl_next(4, mb, 32'd5, 32'(lg), rb, lb, eb, ub, wb);
    qb.push_back(mk(mb, wb));
    mc = mdl_next(6, mc, 32'd0, 32'(lg), rb, lb, eb, ub, wc);
    qc.push_back(mk(mc, wc));
    pg = if_c.gray;
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    chk("a_gray", 32'(if_a.gray), 32'(ea.gray));
    chk("a_bin",  32'(if_a.bin),  32'(ea.bin));
    chk("a_wrap", 32'(if_a.wrap), 32'(ea.wrap));
    eb_ = qb.pop_front();
    chk("b_gray", 32'(if_b.gray), 32'(eb_.gray));
    chk("b_bin",  32'(if_b.bin),  32'(eb_.bin));
    chk("b_wrap", 32'(if_b.wrap), 32'(eb_.wrap));
    ec = qc.pop_front();
    chk("c_gray", 32'(if_c.gray), 32'(ec.gray));
    chk("c_bin",  32'(if_c.bin),  32'(ec.bin));
    chk("c_wrap", 32'(if_c.wrap), 32'(ec.wrap));
    if (rb && !lb && eb) chk("c_onebit", 32'($countones(if_c.gray ^ pg)), 32'd1);
  endtask

  logic [3:0] gseq [16];

  initial begin
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    if_a.en = 1'b0; if_a.up = 1'b0; if_a.load = 1'b0; if_a.load_gray = '0;
    if_b.en = 1'b0; if_b.up = 1'b0; if_b.load = 1'b0; if_b.load_gray = '0;
    if_c.en = 1'b0; if_c.up = 1'b0; if_c.load = 1'b0; if_c.load_gray = '0;

    // reset with en high on the second edge: still reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("rst_a_gray", 32'(if_a.gray), 32'h0);
    chk("rst_a_bin",  32'(if_a.bin),  32'h0);
    chk("rst_a_wrap", 32'(if_a.wrap), 32'h0);
    chk("rst_b_gray", 32'(if_b.gray), 32'h7);
    chk("rst_b_bin",  32'(if_b.bin),  32'h5);

    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1, 1);
      chk("up_gray", 32'(if_a.gray), 32'(gseq[i]));
      chk("up_wrap", 32'(if_a.wrap), 32'(i == 15));
    end

    step(1, 0, 0, 1, 0);
    chk("dn_wrap_bin",  32'(if_a.bin),  32'hF);
    chk("dn_wrap_gray", 32'(if_a.gray), 32'h8);
    chk("dn_wrap_flag", 32'(if_a.wrap), 32'h1);
    step(1, 0, 0, 1, 0);
    chk("dn_bin",  32'(if_a.bin),  32'hE);
    chk("dn_gray", 32'(if_a.gray), 32'h9);
    chk("dn_flag", 32'(if_a.wrap), 32'h0);

    step(1, 1, 'hD, 1, 1);
    chk("ld_gray", 32'(if_a.gray), 32'hD);
    chk("ld_bin",  32'(if_a.bin),  32'h9);
    step(1, 1, 'h6, 1, 0);
    chk("ld_en_gray", 32'(if_a.gray), 32'h6);
    chk("ld_en_bin",  32'(if_a.bin),  32'h4);

    for (int i = 0; i < 5; i++) begin
      step(1, 0, 'h3, 0, 1);
      chk("hold_gray", 32'(if_a.gray), 32'h6);
      chk("hold_bin",  32'(if_a.bin),  32'h4);
      chk("hold_wrap", 32'(if_a.wrap), 32'h0);
    end

    // reset mid-count on the RST_VAL=5 instance
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
    chk("mid_b_bin", 32'(if_b.bin), 32'hA);
    step(0, 1, 'h3, 1, 1);
    chk("mid_rst_bin",  32'(if_b.bin),  32'h5);
    chk("mid_rst_gray", 32'(if_b.gray), 32'h7);
    step(1, 0, 0, 1, 1);
    chk("resume_bin", 32'(if_b.bin), 32'h6);
    step(1, 0, 0, 1, 1);
    chk("rev_up_bin", 32'(if_b.bin), 32'h7);
    step(1, 0, 0, 1, 0);
    chk("rev_dn_bin", 32'(if_b.bin), 32'h6);

    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 63) != 0) ? 1 : 0,
           ($urandom_range(0, 15) == 0) ? 1 : 0,
           int'($urandom_range(0, 63)),
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
